lfsr_core: RTL and testbench

Parametrised linear-feedback shift register engine for the LFSR block family. It generalises the fixed right-shifting register: width is parametrised, taps are runtime-programmable, and Fibonacci and Galois feedback are selectable per step. It also provides seed loading, automatic recovery from the all-zero lock-up state, and period measurement. It sits between the control/register interface and any consumer of the pseudo-random serial or parallel stream.

---
 rtl/lfsr_pkg.sv | 13 +
 rtl/lfsr_step.sv | 30 +++
 rtl/lfsr_core.sv | 116 +++++++++++
 tb/tb_lfsr_core.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR block family: feedback mode encoding and
// the legal range of register widths.
package lfsr_pkg;

  typedef enum logic {
    MODE_FIB    = 1'b0,
    MODE_GALOIS = 1'b1
  } lfsr_mode_e;

  localparam int LFSR_WIDTH_MIN = 2;
  localparam int LFSR_WIDTH_MAX = 32;

endpackage

// File: rtl/lfsr_step.sv
// Combinational single-step next-state logic for a right-shifting LFSR,
// selectable between Fibonacci and Galois feedback.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] state_i,
  input  logic [WIDTH-1:0] taps_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             zero_o
);

  logic             fibFeedback;
  logic [WIDTH-1:0] fibNext;
  logic [WIDTH-1:0] galoisNext;

  // Fibonacci folds the tapped bits into the MSB; Galois injects the taps
  // wherever the bit leaving position 0 was a one.
  always_comb begin
    fibFeedback = ^(state_i & taps_i);
    fibNext     = {fibFeedback, state_i[WIDTH-1:1]};
    galoisNext  = (state_i >> 1) ^ (taps_i & {WIDTH{state_i[0]}});
  end

  assign next_o = (mode_i == MODE_GALOIS) ? galoisNext : fibNext;
  assign zero_o = (state_i == '0);

endmodule

// File: rtl/lfsr_core.sv
// LFSR engine: seed/tap registers, load and step sequencing, lock-up recovery,
// and period measurement built around the shared lfsr_step next-state logic.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               CNT_W        = 16,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = 8'hB8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             taps_wr_i,
  input  logic [WIDTH-1:0] taps_i,
  input  logic             mode_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o,
  output logic             s_out_o,
  output logic             wrapped_o,
  output logic [CNT_W-1:0] period_o,
  output logic             lockup_o
);

  logic [WIDTH-1:0] state_q,   state_d;
  logic [WIDTH-1:0] seed_q,    seed_d;
  logic [WIDTH-1:0] taps_q,    taps_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [CNT_W-1:0] period_q,  period_d;
  logic             wrapped_q, wrapped_d;
  logic             lockup_q,  lockup_d;

  logic [WIDTH-1:0] nextState;
  logic             stateZero;
  logic [CNT_W-1:0] countInc;

  lfsr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .state_i (state_q),
    .taps_i  (taps_q),
    .mode_i  (mode_i),
    .next_o  (nextState),
    .zero_o  (stateZero)
  );

  // Saturating increment; the same value feeds both count and period.
  assign countInc = (&count_q) ? count_q : count_q + CNT_W'(1);

  assign taps_d = taps_wr_i ? taps_i : taps_q;

  // Load outranks step. A zero seed is never stored, so seed_q is always a
  // valid recovery value when the state collapses to zero.
  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    count_d   = count_q;
    period_d  = period_q;
    wrapped_d = 1'b0;
    lockup_d  = 1'b0;
    if (load_i) begin
      count_d = '0;
      if (seed_i == '0) begin
        state_d  = DEFAULT_SEED;
        seed_d   = DEFAULT_SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = seed_i;
        seed_d  = seed_i;
      end
    end else if (step_i) begin
      if (stateZero) begin
        state_d  = seed_q;
        count_d  = '0;
        lockup_d = 1'b1;
      end else begin
        state_d = nextState;
        if (nextState == seed_q) begin
          wrapped_d = 1'b1;
          period_d  = countInc;
          count_d   = '0;
        end else begin
          count_d = countInc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= DEFAULT_SEED;
      seed_q    <= DEFAULT_SEED;
      taps_q    <= DEFAULT_TAPS;
      count_q   <= '0;
      period_q  <= '0;
      wrapped_q <= 1'b0;
      lockup_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      taps_q    <= taps_d;
      count_q   <= count_d;
      period_q  <= period_d;
      wrapped_q <= wrapped_d;
      lockup_q  <= lockup_d;
    end
  end

  assign state_o   = state_q;
  assign s_out_o   = state_q[0];
  assign wrapped_o = wrapped_q;
  assign period_o  = period_q;
  assign lockup_o  = lockup_q;

endmodule

// File: tb/tb_lfsr_core.sv
// Self-checking bench for lfsr_core at WIDTH=4: directed sequences pinned by
// literal values plus randomized traffic checked against a behavioural model.
module tb_lfsr_core;

  localparam int W     = 4;
  localparam int CW    = 16;
  localparam int CMAX  = 65535;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [W-1:0]  seed = '0;
  logic          tapsWr = 1'b0;
  logic [W-1:0]  taps = '0;
  logic          mode = 1'b0;
  logic          step = 1'b0;
  logic [W-1:0]  state;
  logic          sOut;
  logic          wrapped;
  logic [CW-1:0] period;
  logic          lockup;

  int nVec = 0;
  int nMiss = 0;
  logic checkEn = 1'b1;

  // Reference model state, kept as plain integers.
  int mState, mSeed, mTaps, mCount, mPeriod;
  bit mWrap, mLock;

  lfsr_core #(
    .WIDTH        (W),
    .CNT_W        (CW),
    .DEFAULT_TAPS (4'h3),
    .DEFAULT_SEED (4'h1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .seed_i    (seed),
    .taps_wr_i (tapsWr),
    .taps_i    (taps),
    .mode_i    (mode),
    .step_i    (step),
    .state_o   (state),
    .s_out_o   (sOut),
    .wrapped_o (wrapped),
    .period_o  (period),
    .lockup_o  (lockup)
  );

  always #5 clk = ~clk;

  function automatic int refNext(input int s, input int t, input bit galois);
    int ones;
    ones = 0;
    if (galois)
      return (s / 2) ^ ((s % 2 == 1) ? t : 0);
    for (int i = 0; i < W; i++)
      if (((s >> i) & 1) == 1 && ((t >> i) & 1) == 1) ones++;
    return (s / 2) + (ones % 2) * (1 << (W - 1));
  endfunction

  function automatic int satInc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mState <= 1; mSeed <= 1; mTaps <= 3; mCount <= 0; mPeriod <= 0;
      mWrap <= 1'b0; mLock <= 1'b0;
    end else begin
      mWrap <= 1'b0;
      mLock <= 1'b0;
      if (tapsWr) mTaps <= int'(taps);
      if (load) begin
        mCount <= 0;
        if (seed == 0) begin
          mState <= 1; mSeed <= 1; mLock <= 1'b1;
        end else begin
          mState <= int'(seed); mSeed <= int'(seed);
        end
      end else if (step) begin
        if (mState == 0) begin
          mState <= mSeed; mCount <= 0; mLock <= 1'b1;
        end else begin
          mState <= refNext(mState, mTaps, mode);
          if (refNext(mState, mTaps, mode) == mSeed) begin
            mWrap <= 1'b1; mPeriod <= satInc(mCount); mCount <= 0;
          end else begin
            mCount <= satInc(mCount);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, all outputs are compared against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("mdlState",   int'(state),   mState);
      checkOutput("mdlSOut",    int'(sOut),    mState % 2);
      checkOutput("mdlWrapped", int'(wrapped), int'(mWrap));
      checkOutput("mdlPeriod",  int'(period),  mPeriod);
      checkOutput("mdlLockup",  int'(lockup),  int'(mLock));
    end
  end

  task automatic applyStimulus(input logic ld, input logic [W-1:0] sd, input logic tw,
                               input logic [W-1:0] tp, input logic md, input logic st);
    load = ld; seed = sd; tapsWr = tw; taps = tp; mode = md; step = st;
    @(posedge clk);
    #1;
    load = 1'b0; tapsWr = 1'b0; step = 1'b0;
  endtask

  logic [W-1:0] fibSeq [15];

  initial begin
    fibSeq = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
               4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};

    // Held reset with step asserted must not move anything.
    step = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstState",   int'(state),   1);
    checkOutput("rstSOut",    int'(sOut),    1);
    checkOutput("rstPeriod",  int'(period),  0);
    checkOutput("rstWrapped", int'(wrapped), 0);
    checkOutput("rstLockup",  int'(lockup),  0);
    step = 1'b0;
    reset = 1'b0;

    // Fibonacci, taps 3, seed 1.
    applyStimulus(1'b1, 4'h1, 1'b1, 4'h3, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
      checkOutput("fibState", int'(state), int'(fibSeq[i]));
      checkOutput("fibWrapped", int'(wrapped), (i == 14) ? 1 : 0);
    end
    checkOutput("fibPeriod", int'(period), 15);

    // Galois, taps C, seed 1.
    applyStimulus(1'b1, 4'h1, 1'b1, 4'hC, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1);
    checkOutput("galFirst", int'(state), 12);
    for (int i = 0; i < 14; i++)
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1);
    checkOutput("galState",   int'(state),   1);
    checkOutput("galWrapped", int'(wrapped), 1);
    checkOutput("galPeriod",  int'(period),  15);

    // Zero seed substitution, then drain to zero with empty taps.
    applyStimulus(1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0);
    checkOutput("zeroSeedState",  int'(state),  1);
    checkOutput("zeroSeedLockup", int'(lockup), 1);
    for (int i = 0; i < 8 && state != 0; i++)
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("drainZero", int'(state), 0);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("recoverState",   int'(state),   1);
    checkOutput("recoverLockup",  int'(lockup),  1);
    checkOutput("recoverWrapped", int'(wrapped), 0);

    // load+step: load wins; taps_wr+step: old taps used for that step.
    applyStimulus(1'b1, 4'h5, 1'b1, 4'h3, 1'b0, 1'b1);
    checkOutput("loadStepState", int'(state), 5);
    applyStimulus(1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b1);
    checkOutput("tapsOldState", int'(state), 10);
    applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("tapsNewState", int'(state),   5);
    checkOutput("tapsWrapped",  int'(wrapped), 1);
    checkOutput("shortPeriod",  int'(period),  2);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom % 8) == 0, W'($urandom), ($urandom % 10) == 0,
                    W'($urandom), 1'($urandom), ($urandom % 4) != 0);

    // Asynchronous reset mid-sequence at state B.
    applyStimulus(1'b1, 4'h1, 1'b1, 4'h3, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("preRstState", int'(state), 11);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncRstState",  int'(state),  1);
    checkOutput("asyncRstPeriod", int'(period), 0);
    checkOutput("asyncRstSOut",   int'(sOut),   1);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (3) applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    checkOutput("postRstState", int'(state), 2);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
